cmp_sar_search: RTL and testbench

Successive-approximation search controller that drives the operand side of the team's 16-bit combinational magnitude comparator. The comparator's other operand is an unknown value B. The controller resolves B one bit per probe, MSB first, from the comparator's eq/gt/lt flags. It sits upstream of the comparator, issuing trial operands and consuming its result flags, and returns the recovered value with an exactness/consistency verdict.

---
 rtl/cmp_pkg.sv | 19 +
 rtl/cmp_sar_search_if.sv | 31 +++
 rtl/cmp_sar_search_settle_cnt.sv | 29 ++
 rtl/cmp_sar_search.sv | 113 +++++++++++
 tb/tb_cmp_sar_search.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared types, defaults and flag check for the comparator SAR search
package cmp_pkg;

  localparam int CMP_WIDTH  = 16;
  localparam int CMP_SETTLE = 1;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_WAIT        = 2'd1,
    ST_VERIFY_WAIT = 2'd2,
    ST_DONE        = 2'd3
  } sar_state_e;

  // Exactly one of eq/gt/lt may be high for a trustworthy comparator sample.
  function automatic logic flags_onehot(input logic eq, input logic gt, input logic lt);
    return ({eq, gt, lt} == 3'b100) || ({eq, gt, lt} == 3'b010) || ({eq, gt, lt} == 3'b001);
  endfunction

endpackage

// File: rtl/cmp_sar_search_if.sv
// rtl/cmp_sar_search_if.sv - control, comparator and result signals of the SAR search
interface cmp_sar_search_if
  import cmp_pkg::*;
#(
  parameter int WIDTH = CMP_WIDTH
);

  logic             start;
  logic             cmp_eq;
  logic             cmp_gt;
  logic             cmp_lt;
  logic [WIDTH-1:0] trial;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             exact;
  logic             err;

  // Controller side: drives the trial operand and the result, consumes flags.
  modport master (
    input  start, cmp_eq, cmp_gt, cmp_lt,
    output trial, busy, done, result, exact, err
  );

  // Environment side: requests searches and supplies comparator flags.
  modport slave (
    output start, cmp_eq, cmp_gt, cmp_lt,
    input  trial, busy, done, result, exact, err
  );

endinterface

// File: rtl/cmp_sar_search_settle_cnt.sv
// rtl/cmp_sar_search_settle_cnt.sv - loadable settle down-counter with zero flag
module sar_settle_cnt #(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic zero
);

  localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE);

  logic [CW-1:0] cnt;

  // Reload on request, otherwise count down and park at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/cmp_sar_search.sv
// rtl/cmp_sar_search.sv - MSB-first successive-approximation search over a magnitude comparator
module cmp_sar_search
  import cmp_pkg::*;
#(
  parameter int WIDTH  = CMP_WIDTH,
  parameter int SETTLE = CMP_SETTLE
) (
  input  logic             clk,
  input  logic             rst,
  cmp_sar_search_if.master bus
);

  localparam int KW = $clog2(WIDTH);

  sar_state_e       state;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] trial_q;
  logic [WIDTH-1:0] result_q;
  logic             exact_q;
  logic             err_q;

  logic             cnt_load;
  logic             cnt_zero;
  logic             onehot;
  logic [WIDTH-1:0] bit_k;
  logic [WIDTH-1:0] probe_trial;

  assign onehot = flags_onehot(bus.cmp_eq, bus.cmp_gt, bus.cmp_lt);

  // Every probe gets SETTLE+1 cycles: reload at acceptance and at each WAIT decision.
  assign cnt_load = ((state == ST_IDLE) && bus.start) || ((state == ST_WAIT) && cnt_zero);

  sar_settle_cnt #(.SETTLE(SETTLE)) u_settle (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .zero (cnt_zero)
  );

  // Resolve bit k from gt/lt and raise the next lower bit as the new guess.
  always_comb begin
    bit_k       = {{(WIDTH-1){1'b0}}, 1'b1} << k;
    probe_trial = (bus.cmp_gt ? (trial_q & ~bit_k) : trial_q) | (bit_k >> 1);
  end

  // Search FSM and datapath; flags are only looked at on decision edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      k        <= '0;
      trial_q  <= '0;
      result_q <= '0;
      exact_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            trial_q <= {1'b1, {(WIDTH-1){1'b0}}};
            k       <= KW'(WIDTH - 1);
            exact_q <= 1'b0;
            err_q   <= 1'b0;
            state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_zero) begin
            if (!onehot) begin
              err_q    <= 1'b1;
              exact_q  <= 1'b0;
              result_q <= trial_q;
              state    <= ST_DONE;
            end else if (bus.cmp_eq) begin
              result_q <= trial_q;
              exact_q  <= 1'b1;
              state    <= ST_DONE;
            end else begin
              trial_q <= probe_trial;
              if (k == '0) begin
                state <= ST_VERIFY_WAIT;
              end else begin
                k <= k - KW'(1);
              end
            end
          end
        end
        ST_VERIFY_WAIT: begin
          // A miss with clean flags here means B moved during the search.
          if (cnt_zero) begin
            result_q <= trial_q;
            exact_q  <= bus.cmp_eq;
            err_q    <= !onehot;
            state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.trial  = trial_q;
  assign bus.busy   = (state == ST_WAIT) || (state == ST_VERIFY_WAIT);
  assign bus.done   = (state == ST_DONE);
  assign bus.result = result_q;
  assign bus.exact  = exact_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_cmp_sar_search.sv
// tb/tb_cmp_sar_search.sv - scoreboard bench for cmp_sar_search with an ideal comparator
module tb_cmp_sar_search;
  import cmp_pkg::*;

  localparam int W = CMP_WIDTH;
  localparam int S = CMP_SETTLE;

  typedef struct {
    logic [W-1:0] result;
    logic         exact;
    logic         err;
    int           cycle;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] b_val;
  logic         force_en;
  logic [2:0]   force_flags;

  int n_cmp = 0;
  int n_bad = 0;

  exp_t         sb[$];
  logic [W-1:0] trial_log[$];

  logic [W-1:0] obs_result;
  logic         obs_exact;
  logic         obs_err;
  logic         obs_busy;
  logic         busy_at_e0;
  int           obs_cycle;

  cmp_sar_search_if #(.WIDTH(W)) bus ();

  cmp_sar_search #(.WIDTH(W), .SETTLE(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Ideal comparator against B, with an override for fault injection.
  always_comb begin
    if (force_en) begin
      {bus.cmp_eq, bus.cmp_gt, bus.cmp_lt} = force_flags;
    end else begin
      bus.cmp_eq = (bus.trial == b_val);
      bus.cmp_gt = (bus.trial > b_val);
      bus.cmp_lt = (bus.trial < b_val);
    end
  end

  function automatic exp_t model(input logic [W-1:0] b);
    exp_t e;
    logic [W-1:0] t;
    t = '0;
    for (int kk = W - 1; kk >= 0; kk--) begin
      t[kk] = 1'b1;
      if (t == b) begin
        e.result = t; e.exact = 1'b1; e.err = 1'b0;
        e.cycle  = (W - kk) * (S + 1) + 1;
        return e;
      end
      if (t > b) t[kk] = 1'b0;
    end
    e.result = t; e.exact = (t == b); e.err = 1'b0;
    e.cycle  = (W + 1) * (S + 1) + 1;
    return e;
  endfunction

  task automatic start_pulse();
    @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    busy_at_e0 = bus.busy;
    trial_log.delete();
    trial_log.push_back(bus.trial);
  endtask

  // Waits for done, starting the edge count at edge E0+first; bounded.
  task automatic wait_done(input int first);
    bit ok;
    ok = 1'b0;
    obs_cycle = 0;
    for (int i = first; i <= 200; i++) begin
      @(posedge clk);
      #1;
      trial_log.push_back(bus.trial);
      if (bus.done) begin
        obs_cycle  = i + 1;
        obs_result = bus.result;
        obs_exact  = bus.exact;
        obs_err    = bus.err;
        obs_busy   = bus.busy;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout got no done want done within 200 cycles");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b0; b_val = '0; force_en = 1'b0; force_flags = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus.trial !== '0)  begin n_bad++; $display("FAIL rst_trial got %h want 0", bus.trial); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL rst_done got %b want 0", bus.done); end
    n_cmp++; if (bus.result !== '0) begin n_bad++; $display("FAIL rst_result got %h want 0", bus.result); end
    n_cmp++; if (bus.exact !== 1'b0) begin n_bad++; $display("FAIL rst_exact got %b want 0", bus.exact); end
    n_cmp++; if (bus.err !== 1'b0)  begin n_bad++; $display("FAIL rst_err got %b want 0", bus.err); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    exp_t e;
    b_val = 16'h1234;
    sb.push_back(model(b_val));
    start_pulse();
    wait_done(1);
    e = sb.pop_front();
    n_cmp++; if (busy_at_e0 !== 1'b1) begin n_bad++; $display("FAIL basic_busy_e0 got %b want 1", busy_at_e0); end
    n_cmp++; if (obs_result !== e.result) begin n_bad++; $display("FAIL basic_result got %h want %h", obs_result, e.result); end
    n_cmp++; if (obs_exact !== e.exact) begin n_bad++; $display("FAIL basic_exact got %b want %b", obs_exact, e.exact); end
    n_cmp++; if (obs_err !== e.err) begin n_bad++; $display("FAIL basic_err got %b want %b", obs_err, e.err); end
    n_cmp++; if (obs_cycle !== e.cycle) begin n_bad++; $display("FAIL basic_cycle got %0d want %0d", obs_cycle, e.cycle); end
    n_cmp++; if (obs_busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_at_done got %b want 0", obs_busy); end
    if (trial_log.size() > 8) begin
      n_cmp++; if (trial_log[0] !== 16'h8000) begin n_bad++; $display("FAIL probe0 got %h want 8000", trial_log[0]); end
      n_cmp++; if (trial_log[1] !== 16'h8000) begin n_bad++; $display("FAIL probe0_hold got %h want 8000", trial_log[1]); end
      n_cmp++; if (trial_log[2] !== 16'h4000) begin n_bad++; $display("FAIL probe1 got %h want 4000", trial_log[2]); end
      n_cmp++; if (trial_log[8] !== 16'h1800) begin n_bad++; $display("FAIL probe4 got %h want 1800", trial_log[8]); end
    end else begin
      n_cmp++; n_bad++;
      $display("FAIL probe_log got %0d entries want more than 8", trial_log.size());
    end
    @(posedge clk);
    #1;
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL done_pulse got %b want 0", bus.done); end
    n_cmp++; if (bus.result !== 16'h1234) begin n_bad++; $display("FAIL result_hold got %h want 1234", bus.result); end
  endtask

  task automatic test_corners();
    logic [W-1:0] vals [6];
    exp_t e;
    vals[0] = 16'h8000; vals[1] = 16'h0000; vals[2] = 16'hFFFF;
    vals[3] = 16'h0001; vals[4] = W'($urandom); vals[5] = W'($urandom);
    for (int i = 0; i < 6; i++) begin
      b_val = vals[i];
      sb.push_back(model(b_val));
      start_pulse();
      wait_done(1);
      e = sb.pop_front();
      n_cmp++; if (obs_result !== e.result) begin n_bad++; $display("FAIL corner_result b=%h got %h want %h", vals[i], obs_result, e.result); end
      n_cmp++; if (obs_exact !== e.exact) begin n_bad++; $display("FAIL corner_exact b=%h got %b want %b", vals[i], obs_exact, e.exact); end
      n_cmp++; if (obs_err !== e.err) begin n_bad++; $display("FAIL corner_err b=%h got %b want %b", vals[i], obs_err, e.err); end
      n_cmp++; if (obs_cycle !== e.cycle) begin n_bad++; $display("FAIL corner_cycle b=%h got %0d want %0d", vals[i], obs_cycle, e.cycle); end
    end
  endtask

  task automatic test_bad_flags();
    logic [2:0] pats [2];
    exp_t e;
    pats[0] = 3'b000; pats[1] = 3'b110;
    b_val = 16'h1234;
    for (int i = 0; i < 2; i++) begin
      force_en = 1'b1; force_flags = pats[i];
      e.result = 16'h8000; e.exact = 1'b0; e.err = 1'b1; e.cycle = 3;
      sb.push_back(e);
      start_pulse();
      wait_done(1);
      force_en = 1'b0;
      e = sb.pop_front();
      n_cmp++; if (obs_result !== e.result) begin n_bad++; $display("FAIL bad_result f=%b got %h want %h", pats[i], obs_result, e.result); end
      n_cmp++; if (obs_exact !== e.exact) begin n_bad++; $display("FAIL bad_exact f=%b got %b want %b", pats[i], obs_exact, e.exact); end
      n_cmp++; if (obs_err !== e.err) begin n_bad++; $display("FAIL bad_err f=%b got %b want %b", pats[i], obs_err, e.err); end
      n_cmp++; if (obs_cycle !== e.cycle) begin n_bad++; $display("FAIL bad_cycle f=%b got %0d want %0d", pats[i], obs_cycle, e.cycle); end
    end
  endtask

  task automatic test_b_change();
    exp_t e;
    e.result = 16'h00FF; e.exact = 1'b0; e.err = 1'b0; e.cycle = 35;
    sb.push_back(e);
    b_val = 16'h00FF;
    start_pulse();
    repeat (16) @(posedge clk);
    #1 b_val = 16'h0100;
    wait_done(17);
    e = sb.pop_front();
    n_cmp++; if (obs_result !== e.result) begin n_bad++; $display("FAIL chg_result got %h want %h", obs_result, e.result); end
    n_cmp++; if (obs_exact !== e.exact) begin n_bad++; $display("FAIL chg_exact got %b want %b", obs_exact, e.exact); end
    n_cmp++; if (obs_err !== e.err) begin n_bad++; $display("FAIL chg_err got %b want %b", obs_err, e.err); end
    n_cmp++; if (obs_cycle !== e.cycle) begin n_bad++; $display("FAIL chg_cycle got %0d want %0d", obs_cycle, e.cycle); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    // Reset in the middle of a search clears everything at once.
    b_val = 16'h1234;
    start_pulse();
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (bus.trial !== '0) begin n_bad++; $display("FAIL mid_rst_trial got %h want 0", bus.trial); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy got %b want 0", bus.busy); end
    n_cmp++; if (bus.result !== '0) begin n_bad++; $display("FAIL mid_rst_result got %h want 0", bus.result); end
    n_cmp++; if ({bus.done, bus.exact, bus.err} !== 3'b000) begin n_bad++; $display("FAIL mid_rst_flags got %b want 000", {bus.done, bus.exact, bus.err}); end
    #2 rst = 1'b0;
    // A start while busy must neither restart nor queue a search.
    b_val = 16'h0F0F;
    sb.push_back(model(b_val));
    start_pulse();
    repeat (5) @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done(7);
    e = sb.pop_front();
    n_cmp++; if (obs_result !== e.result) begin n_bad++; $display("FAIL busy_start_result got %h want %h", obs_result, e.result); end
    n_cmp++; if (obs_cycle !== e.cycle) begin n_bad++; $display("FAIL busy_start_cycle got %0d want %0d", obs_cycle, e.cycle); end
    // A start presented during the done cycle is dropped as well.
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL done_start_busy got %b want 0", bus.busy); end
    @(posedge clk);
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL no_queue_busy got %b want 0", bus.busy); end
    // The next proper start resolves normally.
    b_val = 16'h5A5A;
    sb.push_back(model(b_val));
    start_pulse();
    wait_done(1);
    e = sb.pop_front();
    n_cmp++; if (obs_result !== e.result) begin n_bad++; $display("FAIL after_result got %h want %h", obs_result, e.result); end
    n_cmp++; if (obs_exact !== e.exact) begin n_bad++; $display("FAIL after_exact got %b want %b", obs_exact, e.exact); end
    n_cmp++; if (obs_cycle !== e.cycle) begin n_bad++; $display("FAIL after_cycle got %0d want %0d", obs_cycle, e.cycle); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_bad_flags();
    test_b_change();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
